// File: rtl/voice_mix_scheduler.sv
// Polls enabled synth voices over req/ack each frame, mixes L/R with
// saturation and writes one stereo word per frame to the audio FIFO.
module voice_mix_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                           CLK,
   input  logic                           RESET_N,
   input  logic                           RUN,
   input  logic [NUM_VOICES-1:0]          VOICE_EN,
   output logic [NUM_VOICES-1:0]          VOICE_REQ,
   input  logic [NUM_VOICES-1:0]          VOICE_ACK,
   input  logic [NUM_VOICES*2*SAMPLE_W-1:0] VOICE_DATA,
   input  logic                           FIFO_FULL,
   output logic                           LD_FIFO,
   output logic [2*SAMPLE_W-1:0]          TONE,
   input  logic                           CLR_FLAGS,
   output logic                           CLIP,
   output logic                           ACK_TIMEOUT,
   output logic [15:0]                    FRAME_CNT
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int AW    = SAMPLE_W + $clog2(NUM_VOICES) + 1;
   localparam int TW    = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SLOT  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   localparam logic signed [AW-1:0] SMAX =
      {{(AW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [AW-1:0] SMIN = ~SMAX;

   localparam logic [SAMPLE_W-1:0] POS_SAT = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] NEG_SAT = {1'b1, {(SAMPLE_W-1){1'b0}}};

   logic [1:0]              state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    act_q, act_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic signed [AW-1:0]    accl_q, accl_d;
   logic signed [AW-1:0]    accr_q, accr_d;
   logic [2*SAMPLE_W-1:0]   tone_q, tone_d;
   logic                    clip_q, clip_d;
   logic                    ato_q, ato_d;
   logic [15:0]             cnt_q, cnt_d;

   logic [2*SAMPLE_W-1:0]   samp;
   logic [SAMPLE_W-1:0]     smp_l, smp_r;
   logic [IDX_W-1:0]        idx_nx;
   logic                    last;
   logic                    adv;
   logic                    to_write;
   logic                    clip_set;
   logic                    ato_set;
   logic [SAMPLE_W-1:0]     sat_l, sat_r;
   logic                    clip_l, clip_r;

   always_comb begin
      samp = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            samp = VOICE_DATA[i*2*SAMPLE_W +: 2*SAMPLE_W];
         end
      end
   end

   assign smp_l  = samp[2*SAMPLE_W-1:SAMPLE_W];
   assign smp_r  = samp[SAMPLE_W-1:0];
   assign idx_nx = idx_q + 1'b1;
   assign last   = (idx_q == IDX_W'(NUM_VOICES - 1));

   always_comb begin
      VOICE_REQ = '0;
      if (state_q == S_SLOT && act_q) begin
         VOICE_REQ[idx_q] = 1'b1;
      end
   end

   assign LD_FIFO = (state_q == S_WRITE) & ~FIFO_FULL;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      act_d    = act_q;
      tmo_d    = tmo_q;
      accl_d   = accl_q;
      accr_d   = accr_q;
      tone_d   = tone_q;
      cnt_d    = cnt_q;
      adv      = 1'b0;
      to_write = 1'b0;
      clip_set = 1'b0;
      ato_set  = 1'b0;
      sat_l    = '0;
      sat_r    = '0;
      clip_l   = 1'b0;
      clip_r   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (RUN) begin
               idx_d   = '0;
               accl_d  = '0;
               accr_d  = '0;
               tmo_d   = '0;
               act_d   = VOICE_EN[0];
               state_d = S_SLOT;
            end
         end
         S_SLOT: begin
            if (!act_q) begin
               adv = 1'b1;
            end else if (VOICE_ACK[idx_q]) begin
               accl_d = accl_q + {{(AW-SAMPLE_W){smp_l[SAMPLE_W-1]}}, smp_l};
               accr_d = accr_q + {{(AW-SAMPLE_W){smp_r[SAMPLE_W-1]}}, smp_r};
               adv    = 1'b1;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               // silent voice: contributes nothing to the mix
               adv     = 1'b1;
               ato_set = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
            if (adv) begin
               tmo_d = '0;
               if (last) begin
                  state_d  = S_WRITE;
                  to_write = 1'b1;
               end else begin
                  idx_d = idx_nx;
                  act_d = VOICE_EN[idx_nx];
               end
            end
         end
         S_WRITE: begin
            if (!FIFO_FULL) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      sat_l = accl_d[SAMPLE_W-1:0];
      if (accl_d > SMAX) begin
         sat_l  = POS_SAT;
         clip_l = 1'b1;
      end else if (accl_d < SMIN) begin
         sat_l  = NEG_SAT;
         clip_l = 1'b1;
      end

      sat_r = accr_d[SAMPLE_W-1:0];
      if (accr_d > SMAX) begin
         sat_r  = POS_SAT;
         clip_r = 1'b1;
      end else if (accr_d < SMIN) begin
         sat_r  = NEG_SAT;
         clip_r = 1'b1;
      end

      if (to_write) begin
         tone_d   = {sat_l, sat_r};
         clip_set = clip_l | clip_r;
      end
   end

   // a set event in the same cycle as a clear leaves the flag set
   assign clip_d = clip_set | (clip_q & ~CLR_FLAGS);
   assign ato_d  = ato_set  | (ato_q  & ~CLR_FLAGS);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         act_q   <= 1'b0;
         tmo_q   <= '0;
         accl_q  <= '0;
         accr_q  <= '0;
         tone_q  <= '0;
         clip_q  <= 1'b0;
         ato_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         act_q   <= act_d;
         tmo_q   <= tmo_d;
         accl_q  <= accl_d;
         accr_q  <= accr_d;
         tone_q  <= tone_d;
         clip_q  <= clip_d;
         ato_q   <= ato_d;
         cnt_q   <= cnt_d;
      end
   end

   assign TONE        = tone_q;
   assign CLIP        = clip_q;
   assign ACK_TIMEOUT = ato_q;
   assign FRAME_CNT   = cnt_q;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Directed-vector bench for voice_mix_scheduler (TIMEOUT=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_voice_mix_scheduler;

   logic         CLK;
   logic         RESET_N;
   logic         RUN;
   logic [3:0]   VOICE_EN;
   logic [3:0]   VOICE_REQ;
   logic [3:0]   VOICE_ACK;
   logic [127:0] VOICE_DATA;
   logic         FIFO_FULL;
   logic         LD_FIFO;
   logic [31:0]  TONE;
   logic         CLR_FLAGS;
   logic         CLIP;
   logic         ACK_TIMEOUT;
   logic [15:0]  FRAME_CNT;

   int vectors;
   int miscompares;

   voice_mix_scheduler #(
      .NUM_VOICES (4),
      .SAMPLE_W   (16),
      .TIMEOUT    (8)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .RUN         (RUN),
      .VOICE_EN    (VOICE_EN),
      .VOICE_REQ   (VOICE_REQ),
      .VOICE_ACK   (VOICE_ACK),
      .VOICE_DATA  (VOICE_DATA),
      .FIFO_FULL   (FIFO_FULL),
      .LD_FIFO     (LD_FIFO),
      .TONE        (TONE),
      .CLR_FLAGS   (CLR_FLAGS),
      .CLIP        (CLIP),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .FRAME_CNT   (FRAME_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_v(input int i, input logic [15:0] l,
                        input logic [15:0] r);
      VOICE_DATA[i*32 +: 32] = {l, r};
   endtask

   task automatic start_frame();
      RUN = 1'b1;
      tick();
      RUN = 1'b0;
   endtask

   task automatic wait_ld(input int max, output int n);
      n = 0;
      while (LD_FIFO !== 1'b1 && n < max) begin
         tick();
         n++;
      end
   endtask

   int n;
   int pos;
   int pulses;
   int ld_seen;
   int tone_bad;
   int req2;
   logic [3:0] req_or;

   initial begin
      vectors     = 0;
      miscompares = 0;
      RESET_N     = 1'b0;
      RUN         = 1'b0;
      VOICE_EN    = '0;
      VOICE_ACK   = '0;
      VOICE_DATA  = '0;
      FIFO_FULL   = 1'b0;
      CLR_FLAGS   = 1'b0;
      tick();
      tick();
      RESET_N = 1'b1;
      tick();

      chk("rst req", VOICE_REQ, 32'h0);
      chk("rst ld", LD_FIFO, 32'h0);
      chk("rst tone", TONE, 32'h0);
      chk("rst clip", CLIP, 32'h0);
      chk("rst ato", ACK_TIMEOUT, 32'h0);
      chk("rst cnt", FRAME_CNT, 32'h0);

      // basic mix, same-cycle ack, continuous frames
      for (int i = 0; i < 4; i++) set_v(i, 16'h0100, 16'hFF00);
      VOICE_EN  = 4'hF;
      VOICE_ACK = 4'hF;
      RUN       = 1'b1;
      tick();
      chk("mix req0", VOICE_REQ, 32'h1);
      tick();
      chk("mix req1", VOICE_REQ, 32'h2);
      tick();
      chk("mix req2", VOICE_REQ, 32'h4);
      tick();
      chk("mix req3", VOICE_REQ, 32'h8);
      tick();
      chk("mix ld", LD_FIFO, 32'h1);
      chk("mix tone", TONE, 32'h0400FC00);
      chk("mix cnt0", FRAME_CNT, 32'h0);
      chk("mix clip", CLIP, 32'h0);
      tick();
      chk("mix ld off", LD_FIFO, 32'h0);
      chk("mix cnt1", FRAME_CNT, 32'h1);
      pos    = 0;
      pulses = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (LD_FIFO === 1'b1) begin
            pulses++;
            pos = i;
         end
      end
      RUN = 1'b0;
      chk("mix pulses", pulses, 32'd1);
      chk("mix period", pos + 1, 32'd6);
      chk("mix cnt2", FRAME_CNT, 32'h2);
      tick();
      chk("idle req", VOICE_REQ, 32'h0);

      // saturation both directions
      for (int i = 0; i < 4; i++) set_v(i, 16'h7000, 16'h9000);
      start_frame();
      wait_ld(20, n);
      chk("sat ld", LD_FIFO, 32'h1);
      chk("sat lat", n, 32'd4);
      chk("sat tone", TONE, 32'h7FFF8000);
      chk("sat clip", CLIP, 32'h1);
      tick();
      CLR_FLAGS = 1'b1;
      tick();
      CLR_FLAGS = 1'b0;
      chk("sat clr", CLIP, 32'h0);
      chk("sat cnt", FRAME_CNT, 32'h3);

      // FIFO backpressure in WRITE
      set_v(0, 16'h0001, 16'hFFFF);
      set_v(1, 16'h0002, 16'hFFFE);
      set_v(2, 16'h0003, 16'hFFFD);
      set_v(3, 16'h0004, 16'hFFFC);
      FIFO_FULL = 1'b1;
      start_frame();
      repeat (4) tick();
      ld_seen  = 0;
      tone_bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) tick();
         if (LD_FIFO !== 1'b0) ld_seen++;
         if (TONE !== 32'h000AFFF6) tone_bad++;
      end
      chk("bp no ld", ld_seen, 32'd0);
      chk("bp tone hold", tone_bad, 32'd0);
      chk("bp req", VOICE_REQ, 32'h0);
      FIFO_FULL = 1'b0;
      #1;
      chk("bp ld", LD_FIFO, 32'h1);
      chk("bp cnt pre", FRAME_CNT, 32'h3);
      tick();
      chk("bp ld off", LD_FIFO, 32'h0);
      chk("bp cnt", FRAME_CNT, 32'h4);
      ld_seen = 0;
      repeat (8) begin
         tick();
         if (LD_FIFO !== 1'b0) ld_seen++;
      end
      chk("bp no dup", ld_seen, 32'd0);
      chk("bp cnt hold", FRAME_CNT, 32'h4);
      chk("bp clip", CLIP, 32'h0);

      // voice 2 never acks
      for (int i = 0; i < 4; i++) set_v(i, 16'h0010, 16'h0020);
      VOICE_ACK = 4'b1011;
      start_frame();
      req2 = 0;
      n    = 0;
      while (LD_FIFO !== 1'b1 && n < 40) begin
         if (VOICE_REQ[2] === 1'b1) req2++;
         tick();
         n++;
      end
      chk("tmo ld", LD_FIFO, 32'h1);
      chk("tmo req2 len", req2, 32'd8);
      chk("tmo lat", n, 32'd11);
      chk("tmo tone", TONE, 32'h00300060);
      chk("tmo flag", ACK_TIMEOUT, 32'h1);
      tick();
      CLR_FLAGS = 1'b1;
      tick();
      CLR_FLAGS = 1'b0;
      chk("tmo clr", ACK_TIMEOUT, 32'h0);
      chk("tmo cnt", FRAME_CNT, 32'h5);

      // sparse enables, RUN dropped mid-frame, counter wrap
      VOICE_ACK = 4'hF;
      VOICE_EN  = 4'b0101;
      set_v(0, 16'h1234, 16'h0001);
      set_v(1, 16'h7FFF, 16'h7FFF);
      set_v(2, 16'h0100, 16'h0002);
      set_v(3, 16'h7FFF, 16'h7FFF);
      dut.cnt_q = 16'hFFFF;
      RUN = 1'b1;
      tick();
      req_or = VOICE_REQ;
      tick();
      RUN = 1'b0;
      req_or |= VOICE_REQ;
      n = 2;
      while (LD_FIFO !== 1'b1 && n < 20) begin
         tick();
         n++;
         req_or |= VOICE_REQ;
      end
      chk("en ld", LD_FIFO, 32'h1);
      chk("en lat", n, 32'd5);
      chk("en req", req_or, 32'h5);
      chk("en tone", TONE, 32'h13340003);
      tick();
      chk("wrap cnt", FRAME_CNT, 32'h0);
      ld_seen = 0;
      req_or  = '0;
      repeat (10) begin
         tick();
         if (LD_FIFO !== 1'b0) ld_seen++;
         req_or |= VOICE_REQ;
      end
      chk("idle ld", ld_seen, 32'd0);
      chk("idle req2", req_or, 32'h0);

      // reset mid-frame with REQ high
      VOICE_EN  = 4'hF;
      VOICE_ACK = 4'b0011;
      for (int i = 0; i < 4; i++) set_v(i, 16'h0100, 16'h0100);
      start_frame();
      tick();
      tick();
      chk("mr req", VOICE_REQ, 32'h4);
      RESET_N = 1'b0;
      #1;
      chk("mr req0", VOICE_REQ, 32'h0);
      chk("mr tone", TONE, 32'h0);
      tick();
      chk("mr req1", VOICE_REQ, 32'h0);
      chk("mr ld", LD_FIFO, 32'h0);
      chk("mr cnt", FRAME_CNT, 32'h0);
      chk("mr ato", ACK_TIMEOUT, 32'h0);
      RESET_N   = 1'b1;
      VOICE_ACK = 4'hF;
      tick();
      chk("mr idle", VOICE_REQ, 32'h0);
      start_frame();
      wait_ld(20, n);
      chk("mr ld2", LD_FIFO, 32'h1);
      chk("mr fresh", TONE, 32'h04000400);
      tick();
      chk("mr cnt1", FRAME_CNT, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
